// File: rtl/demux16_deser_if.sv
// demux16_deser_if: bundles the serial bit input, the parallel word output handshake and the
// status outputs of the serial-to-parallel receive end.
//   master modport : bit source / word consumer side (drives bits and word_ready)
//   slave  modport : the deserializer itself
// Signals:
//   bit_in, bit_valid, bit_ready, frame_start       serial bit handshake
//   word_out[WIDTH], word_valid, word_ready          assembled word handshake
//   idx[IDX_W], partial_drop, parity_err             status
`timescale 1ns/1ps
interface demux16_deser_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
);
  logic             bit_in;
  logic             bit_valid;
  logic             bit_ready;
  logic             frame_start;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [IDX_W-1:0] idx;
  logic             partial_drop;
  logic             parity_err;

  modport master (
    output bit_in, bit_valid, frame_start, word_ready,
    input  bit_ready, word_out, word_valid, idx, partial_drop, parity_err
  );

  modport slave (
    input  bit_in, bit_valid, frame_start, word_ready,
    output bit_ready, word_out, word_valid, idx, partial_drop, parity_err
  );
endinterface

// File: rtl/demux16_deser.sv
// demux16_deser: receive end of a bit-serial 16:1 mux path. Collects one bit per accepted
// handshake into position idx (LSB first) and presents the assembled word through a
// valid/ready output register. A shadow register collects the next word while the previous
// one is still held, so only the completing bit can ever be stalled.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   io_bus   demux16_deser_if.slave (bit handshake, word handshake, idx, partial_drop,
//            parity_err)
// Optional feature: define DEMUX16_PARITY_EN to expect an even-parity bit after every word;
// the word is published only once the parity bit is accepted and parity_err reports the check.
// Without it parity_err is tied to 0.
`timescale 1ns/1ps
module demux16_deser #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned IDX_W = 4
) (
  input logic              i_clk,
  input logic              i_rst_n,
  demux16_deser_if.slave   io_bus
);

  if (WIDTH != (1 << IDX_W)) begin : g_bad_params
    $error("demux16_deser: WIDTH must equal 2**IDX_W");
  end

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(WIDTH - 1);

`ifdef DEMUX16_PARITY_EN
  typedef enum logic [0:0] {StCollect, StParity} state_e;
`else
  typedef enum logic [0:0] {StCollect} state_e;
`endif

  state_e           r_state,        w_state_d;
  logic [IDX_W-1:0] r_idx,          w_idx_d;
  logic [WIDTH-1:0] r_shadow,       w_shadow_d;
  logic [WIDTH-1:0] r_word,         w_word_d;
  logic             r_word_valid,   w_word_valid_d;
  logic             r_partial_drop, w_partial_drop_d;
`ifdef DEMUX16_PARITY_EN
  logic             r_parity_err,   w_parity_err_d;
`endif

  logic w_pending;
  logic w_bit_ready;
  logic w_accept;

  // The completing accept is the only one that writes word_out; stall it while an
  // unconsumed word is held and the consumer is not taking it this cycle.
`ifdef DEMUX16_PARITY_EN
  assign w_pending = (r_state == StParity);
`else
  assign w_pending = (r_state == StCollect) && (r_idx == LastIdx);
`endif
  assign w_bit_ready = !(w_pending && r_word_valid && !io_bus.word_ready);
  assign w_accept    = io_bus.bit_valid && w_bit_ready;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state        <= StCollect;
      r_idx          <= '0;
      r_shadow       <= '0;
      r_word         <= '0;
      r_word_valid   <= 1'b0;
      r_partial_drop <= 1'b0;
`ifdef DEMUX16_PARITY_EN
      r_parity_err   <= 1'b0;
`endif
    end else begin
      r_state        <= w_state_d;
      r_idx          <= w_idx_d;
      r_shadow       <= w_shadow_d;
      r_word         <= w_word_d;
      r_word_valid   <= w_word_valid_d;
      r_partial_drop <= w_partial_drop_d;
`ifdef DEMUX16_PARITY_EN
      r_parity_err   <= w_parity_err_d;
`endif
    end
  end

  always_comb begin
    w_state_d        = r_state;
    w_idx_d          = r_idx;
    w_shadow_d       = r_shadow;
    w_word_d         = r_word;
    w_word_valid_d   = r_word_valid;
    w_partial_drop_d = 1'b0;
`ifdef DEMUX16_PARITY_EN
    w_parity_err_d   = r_parity_err;
`endif

    // Consumption first; a word loading in the same cycle sets valid again below.
    if (r_word_valid && io_bus.word_ready) begin
      w_word_valid_d = 1'b0;
    end

    if (w_accept) begin
      if (io_bus.frame_start) begin
        // Resynchronise: this bit is index 0 of a new word, any partial data is abandoned.
        w_shadow_d[0]    = io_bus.bit_in;
        w_idx_d          = IDX_W'(1);
        w_partial_drop_d = (r_idx != '0);
        w_state_d        = StCollect;
      end else begin
        unique case (r_state)
          StCollect: begin
            w_shadow_d[r_idx] = io_bus.bit_in;
            if (r_idx != LastIdx) begin
              w_idx_d = r_idx + IDX_W'(1);
            end else begin
              w_idx_d = '0;
`ifdef DEMUX16_PARITY_EN
              w_state_d = StParity;
`else
              w_word_d       = w_shadow_d;
              w_word_valid_d = 1'b1;
`endif
            end
          end
`ifdef DEMUX16_PARITY_EN
          StParity: begin
            w_word_d       = r_shadow;
            w_word_valid_d = 1'b1;
            w_parity_err_d = (^r_shadow) ^ io_bus.bit_in;
            w_state_d      = StCollect;
          end
`endif
          default: ;
        endcase
      end
    end
  end

  assign io_bus.bit_ready    = w_bit_ready;
  assign io_bus.word_out     = r_word;
  assign io_bus.word_valid   = r_word_valid;
  assign io_bus.idx          = r_idx;
  assign io_bus.partial_drop = r_partial_drop;
`ifdef DEMUX16_PARITY_EN
  assign io_bus.parity_err   = r_parity_err;
`else
  assign io_bus.parity_err   = 1'b0;
`endif

endmodule

// File: tb/tb_demux16_deser.sv
// tb_demux16_deser: directed, table-driven bench for demux16_deser. Inputs change 1ns after
// the rising edge; outputs are sampled at that same point, away from the edge.
`timescale 1ns/1ps
module tb_demux16_deser;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;
  int   drop_cnt;

  demux16_deser_if #(.WIDTH(16), .IDX_W(4)) bus ();

  demux16_deser #(.WIDTH(16), .IDX_W(4)) u_dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .io_bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts partial_drop pulses; a one-cycle pulse is seen at exactly one edge.
  initial drop_cnt = 0;
  always @(posedge clk) if (bus.partial_drop === 1'b1) drop_cnt++;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  typedef struct {
    logic [15:0] data;
    int          pre_bits;
    logic [15:0] pre_data;
    logic [15:0] exp_word;
    int          exp_drops;
  } vec_t;

  vec_t vecs [4];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic fs);
    int n;
    bus.bit_valid   = 1'b1;
    bus.bit_in      = b;
    bus.frame_start = fs;
    n = 0;
    #0;
    while (bus.bit_ready !== 1'b1 && n < 64) begin
      step();
      n++;
    end
    if (bus.bit_ready !== 1'b1) chk("bit_ready_timeout", {31'b0, bus.bit_ready}, 32'd1);
    step();
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
  endtask

  task automatic send_bits(input logic [15:0] data, input int first, input int last,
                           input logic fs_first);
    for (int i = first; i <= last; i++) begin
      send_bit(data[i], fs_first && (i == first));
    end
  endtask

  initial begin
    logic [15:0] w;
    int d0;
    n_checks        = 0;
    n_fail          = 0;
    rst_n           = 1'b0;
    bus.bit_in      = 1'b0;
    bus.bit_valid   = 1'b0;
    bus.frame_start = 1'b0;
    bus.word_ready  = 1'b0;

    vecs[0] = '{data: 16'hA5C3, pre_bits: 0, pre_data: 16'h0000, exp_word: 16'hA5C3,
                exp_drops: 0};
    vecs[1] = '{data: 16'h1234, pre_bits: 7, pre_data: 16'h0055, exp_word: 16'h1234,
                exp_drops: 1};
    vecs[2] = '{data: 16'h0F0F, pre_bits: 3, pre_data: 16'h0007, exp_word: 16'h0F0F,
                exp_drops: 1};
    vecs[3] = '{data: 16'h8001, pre_bits: 0, pre_data: 16'h0000, exp_word: 16'h8001,
                exp_drops: 0};

    step();
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_idx",        {28'b0, bus.idx},         32'd0);
    chk("rst_word_valid", {31'b0, bus.word_valid},  32'd0);
    chk("rst_word_out",   {16'b0, bus.word_out},    32'd0);
    chk("rst_drop",       {31'b0, bus.partial_drop},32'd0);
    chk("rst_parity_err", {31'b0, bus.parity_err},  32'd0);
    chk("rst_bit_ready",  {31'b0, bus.bit_ready},   32'd1);

`ifndef DEMUX16_PARITY_EN
    // Table: optional partial word, then a full frame with word_ready held high.
    bus.word_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      d0 = drop_cnt;
      if (vecs[v].pre_bits > 0) begin
        send_bits(vecs[v].pre_data, 0, vecs[v].pre_bits - 1, 1'b1);
        chk("tbl_pre_idx", {28'b0, bus.idx}, vecs[v].pre_bits);
      end
      send_bits(vecs[v].data, 0, 15, 1'b1);
      chk("tbl_word_valid", {31'b0, bus.word_valid}, 32'd1);
      chk("tbl_word_out",   {16'b0, bus.word_out},   {16'b0, vecs[v].exp_word});
      chk("tbl_idx_wrap",   {28'b0, bus.idx},        32'd0);
      step();
      chk("tbl_consumed",   {31'b0, bus.word_valid}, 32'd0);
      chk("tbl_word_hold",  {16'b0, bus.word_out},   {16'b0, vecs[v].exp_word});
      chk("tbl_drops",      drop_cnt - d0,           vecs[v].exp_drops);
    end

    // Backpressure: word 1 held, word 2 bits 0..14 flow, bit 15 stalls until ready.
    bus.word_ready = 1'b0;
    d0 = drop_cnt;
    send_bits(16'h0001, 0, 15, 1'b1);
    chk("bp_w1_valid", {31'b0, bus.word_valid}, 32'd1);
    chk("bp_w1_word",  {16'b0, bus.word_out},   32'h0001);
    w = 16'h8000;
    for (int i = 0; i < 15; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = w[i];
      #1;
      chk("bp_ready_early", {31'b0, bus.bit_ready}, 32'd1);
      send_bit(w[i], i == 0);
    end
    bus.bit_valid = 1'b1;
    bus.bit_in    = w[15];
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("bp_ready_stall", {31'b0, bus.bit_ready}, 32'd0);
      step();
      chk("bp_stall_idx",  {28'b0, bus.idx},      32'd15);
      chk("bp_stall_word", {16'b0, bus.word_out}, 32'h0001);
    end
    bus.word_ready = 1'b1;
    #1;
    chk("bp_ready_release", {31'b0, bus.bit_ready}, 32'd1);
    step();
    bus.bit_valid = 1'b0;
    chk("bp_w2_valid", {31'b0, bus.word_valid}, 32'd1);
    chk("bp_w2_word",  {16'b0, bus.word_out},   32'h8000);
    chk("bp_w2_idx",   {28'b0, bus.idx},        32'd0);
    chk("bp_no_drop",  drop_cnt - d0,           32'd0);
    step();
    chk("bp_w2_consumed", {31'b0, bus.word_valid}, 32'd0);

    // Completion on the same edge as the handshake of the held word.
    bus.word_ready = 1'b0;
    send_bits(16'h00FF, 0, 15, 1'b1);
    w = 16'hFF00;
    send_bits(w, 0, 14, 1'b1);
    chk("sim_held_word", {16'b0, bus.word_out}, 32'h00FF);
    bus.bit_valid  = 1'b1;
    bus.bit_in     = w[15];
    bus.word_ready = 1'b1;
    #1;
    chk("sim_ready", {31'b0, bus.bit_ready}, 32'd1);
    step();
    bus.bit_valid = 1'b0;
    chk("sim_valid_kept", {31'b0, bus.word_valid}, 32'd1);
    chk("sim_new_word",   {16'b0, bus.word_out},   32'hFF00);
    step();
    chk("sim_consumed",   {31'b0, bus.word_valid}, 32'd0);

    // frame_start without bit_valid is ignored; bit_valid=0 holds idx.
    d0 = drop_cnt;
    w  = 16'h001F;
    send_bits(w, 0, 4, 1'b1);
    bus.frame_start = 1'b1;
    step();
    step();
    bus.frame_start = 1'b0;
    chk("fs_novalid_idx", {28'b0, bus.idx}, 32'd5);
    send_bits(w, 5, 15, 1'b0);
    chk("fs_novalid_word", {16'b0, bus.word_out}, 32'h001F);
    chk("fs_novalid_drop", drop_cnt - d0,        32'd0);
    step();

    // Reset mid-word with a held output word.
    bus.word_ready = 1'b0;
    send_bits(16'h1111, 0, 15, 1'b1);
    send_bits(16'h0000, 0, 8, 1'b1);
    chk("mr_pre_idx",   {28'b0, bus.idx},        32'd9);
    chk("mr_pre_valid", {31'b0, bus.word_valid}, 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mr_idx",   {28'b0, bus.idx},          32'd0);
    chk("mr_valid", {31'b0, bus.word_valid},   32'd0);
    chk("mr_word",  {16'b0, bus.word_out},     32'd0);
    chk("mr_drop",  {31'b0, bus.partial_drop}, 32'd0);
    chk("mr_perr",  {31'b0, bus.parity_err},   32'd0);
    bus.word_ready = 1'b1;
    send_bits(16'hFFFF, 0, 15, 1'b1);
    chk("mr_after_valid", {31'b0, bus.word_valid}, 32'd1);
    chk("mr_after_word",  {16'b0, bus.word_out},   32'hFFFF);
    step();
`else
    // Parity build: 16 data bits then one even-parity bit.
    bus.word_ready = 1'b1;
    send_bits(16'h0003, 0, 15, 1'b1);
    chk("par_no_early_valid", {31'b0, bus.word_valid}, 32'd0);
    chk("par_idx_wrap",       {28'b0, bus.idx},        32'd0);
    send_bit(1'b0, 1'b0);
    chk("par_valid_1", {31'b0, bus.word_valid}, 32'd1);
    chk("par_word_1",  {16'b0, bus.word_out},   32'h0003);
    chk("par_err_1",   {31'b0, bus.parity_err}, 32'd0);
    step();
    send_bits(16'h0007, 0, 15, 1'b1);
    chk("par_no_early_valid2", {31'b0, bus.word_valid}, 32'd0);
    send_bit(1'b0, 1'b0);
    chk("par_valid_2", {31'b0, bus.word_valid}, 32'd1);
    chk("par_word_2",  {16'b0, bus.word_out},   32'h0007);
    chk("par_err_2",   {31'b0, bus.parity_err}, 32'd1);
    step();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
